// File: rtl/vx_dmem_rsp_collector_if.sv
// Bus bundle for vx_dmem_rsp_collector: core dcache request/response, TL A ready and TL D channel.
// The collector takes the slave modport; core and memory models take the master modport.
interface vx_dmem_rsp_collector_if #(
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_LANES-1:0]            core_req_valid;
    logic [NUM_LANES-1:0]            core_req_rw;
    logic [TAG_WIDTH-1:0]            core_req_tag;
    logic [NUM_LANES-1:0]            core_req_ready;
    logic [NUM_LANES-1:0]            mem_a_ready;
    logic [NUM_LANES-1:0]            mem_d_valid;
    logic [3*NUM_LANES-1:0]          mem_d_opcode;
    logic [TAG_WIDTH*NUM_LANES-1:0]  mem_d_source;
    logic [DATA_WIDTH*NUM_LANES-1:0] mem_d_data;
    logic [NUM_LANES-1:0]            mem_d_ready;
    logic                            rsp_valid;
    logic [NUM_LANES-1:0]            rsp_tmask;
    logic [DATA_WIDTH*NUM_LANES-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]            rsp_tag;
    logic                            rsp_ready;
    logic                            timeout_err;

    modport slave (
        input  core_req_valid, core_req_rw, core_req_tag, mem_a_ready,
        input  mem_d_valid, mem_d_opcode, mem_d_source, mem_d_data, rsp_ready,
        output core_req_ready, mem_d_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag, timeout_err
    );

    modport master (
        output core_req_valid, core_req_rw, core_req_tag, mem_a_ready,
        output mem_d_valid, mem_d_opcode, mem_d_source, mem_d_data, rsp_ready,
        input  core_req_ready, mem_d_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag, timeout_err
    );
endinterface

// File: rtl/vx_dmem_rsp_collector.sv
// Gathers per-lane TL D load responses by tag and emits one merged dcache response per tag.
// Optional partial-response timeout enabled by defining DMEM_RSP_TIMEOUT_EN.
//
// state      | meaning
// ST_FREE    | entry unused, may be allocated
// ST_COLLECT | loads issued for tag, gathering D beats
// ST_DONE    | all expected beats in, waiting for output register / response fire
module vx_dmem_rsp_collector #(
    parameter int NUM_LANES      = 4,
    parameter int TAG_WIDTH      = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ENTRIES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                    clock,
    input logic                    reset_n,
    vx_dmem_rsp_collector_if.slave bus
);
    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [1:0]            ent_state [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  ent_tag   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  ent_exp   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  ent_rcv   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] ent_data  [NUM_ENTRIES][NUM_LANES];
    logic [1:0]            nxt_state [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  nxt_tag   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  nxt_exp   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  nxt_rcv   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] nxt_data  [NUM_ENTRIES][NUM_LANES];

    logic                  hit_collect, hit_done, any_free, stall, req_pending;
    logic [IDX_W-1:0]      hit_idx, free_idx;
    logic [NUM_LANES-1:0]  load_vld, load_fire, d_hit, d_ready, beat;
    logic [IDX_W-1:0]      d_idx [NUM_LANES];

    logic                            rsp_valid_q, rsp_fire, out_found, out_load;
    logic [IDX_W-1:0]                out_idx, out_sel;
    logic [NUM_LANES-1:0]            rsp_tmask_q;
    logic [DATA_WIDTH*NUM_LANES-1:0] rsp_data_q, out_data;
    logic [TAG_WIDTH-1:0]            rsp_tag_q;

`ifdef DMEM_RSP_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0]     ent_tmr [NUM_ENTRIES];
    logic [TMR_W-1:0]     nxt_tmr [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ent_alloc, ent_beat;
    logic                 tmo_fire, timeout_err_q;
`endif

    // Lookup against registered state; scanning downwards makes the lowest index win.
    always_comb begin
        hit_collect = 1'b0;
        hit_done    = 1'b0;
        any_free    = 1'b0;
        hit_idx     = '0;
        free_idx    = '0;
        for (int e = NUM_ENTRIES-1; e >= 0; e--) begin
            if (ent_state[e] == ST_COLLECT && ent_tag[e] == bus.core_req_tag) begin
                hit_collect = 1'b1;
                hit_idx     = IDX_W'(e);
            end
            if (ent_state[e] == ST_DONE && ent_tag[e] == bus.core_req_tag) hit_done = 1'b1;
            if (ent_state[e] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(e);
            end
        end
    end

    assign load_vld           = bus.core_req_valid & ~bus.core_req_rw;
    assign stall              = (|load_vld) & ((~hit_collect & ~any_free) | hit_done);
    assign bus.core_req_ready = bus.mem_a_ready & {NUM_LANES{~stall}};
    assign load_fire          = load_vld & bus.core_req_ready;
    assign req_pending        = |(load_vld & ~bus.core_req_ready);
    assign rsp_fire           = rsp_valid_q & bus.rsp_ready;

    // Acks and unmatched data are sunk; a second beat for an already-received lane is held off.
    always_comb begin
        d_hit   = '0;
        d_ready = '0;
        beat    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            d_idx[i] = '0;
            for (int e = NUM_ENTRIES-1; e >= 0; e--) begin
                if (ent_state[e] == ST_COLLECT &&
                    ent_tag[e] == bus.mem_d_source[i*TAG_WIDTH +: TAG_WIDTH]) begin
                    d_hit[i] = 1'b1;
                    d_idx[i] = IDX_W'(e);
                end
            end
            if (bus.mem_d_opcode[i*3 +: 3] == 3'd0) d_ready[i] = 1'b1;
            else d_ready[i] = ~(d_hit[i] & ent_rcv[d_idx[i]][i]);
            beat[i] = bus.mem_d_valid[i] & d_ready[i] & d_hit[i] & (bus.mem_d_opcode[i*3 +: 3] != 3'd0);
        end
    end
    assign bus.mem_d_ready = d_ready;

    always_comb begin
        nxt_state = ent_state;
        nxt_tag   = ent_tag;
        nxt_exp   = ent_exp;
        nxt_rcv   = ent_rcv;
        nxt_data  = ent_data;
`ifdef DMEM_RSP_TIMEOUT_EN
        nxt_tmr   = ent_tmr;
        ent_alloc = '0;
        ent_beat  = '0;
        tmo_fire  = 1'b0;
`endif
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (beat[i] && d_idx[i] == IDX_W'(e)) begin
                    nxt_rcv[e][i]  = 1'b1;
                    nxt_data[e][i] = bus.mem_d_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef DMEM_RSP_TIMEOUT_EN
                    ent_beat[e]    = 1'b1;
`endif
                end
            end
            if (ent_state[e] == ST_COLLECT && hit_collect && hit_idx == IDX_W'(e))
                nxt_exp[e] = ent_exp[e] | load_fire;
            if (ent_state[e] == ST_FREE && (|load_fire) && !hit_collect && free_idx == IDX_W'(e)) begin
                nxt_state[e] = ST_COLLECT;
                nxt_tag[e]   = bus.core_req_tag;
                nxt_exp[e]   = load_fire;
                nxt_rcv[e]   = '0;
`ifdef DMEM_RSP_TIMEOUT_EN
                ent_alloc[e] = 1'b1;
`endif
            end
            // An unfired load lane still carrying this tag may yet widen exp_mask.
            if (ent_state[e] == ST_COLLECT && nxt_rcv[e] == nxt_exp[e] &&
                !(req_pending && ent_tag[e] == bus.core_req_tag))
                nxt_state[e] = ST_DONE;
`ifdef DMEM_RSP_TIMEOUT_EN
            if (ent_alloc[e] || ent_beat[e]) begin
                nxt_tmr[e] = TMR_W'(TIMEOUT_CYCLES - 1);
            end else if (ent_state[e] == ST_COLLECT) begin
                if (ent_tmr[e] == '0) begin
                    nxt_state[e] = ST_DONE;
                    tmo_fire     = 1'b1;
                end else begin
                    nxt_tmr[e] = ent_tmr[e] - 1'b1;
                end
            end
`endif
            if (ent_state[e] == ST_DONE && rsp_fire && out_idx == IDX_W'(e))
                nxt_state[e] = ST_FREE;
        end
    end

    // Selection uses next state so the response lands one cycle after the last beat.
    always_comb begin
        out_found = 1'b0;
        out_sel   = '0;
        out_data  = '0;
        for (int e = NUM_ENTRIES-1; e >= 0; e--) begin
            if (nxt_state[e] == ST_DONE && !(rsp_valid_q && out_idx == IDX_W'(e))) begin
                out_found = 1'b1;
                out_sel   = IDX_W'(e);
            end
        end
        for (int i = 0; i < NUM_LANES; i++)
            if (nxt_rcv[out_sel][i]) out_data[i*DATA_WIDTH +: DATA_WIDTH] = nxt_data[out_sel][i];
        out_load = out_found & (~rsp_valid_q | rsp_fire);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                ent_state[e] <= ST_FREE;
                ent_tag[e]   <= '0;
                ent_exp[e]   <= '0;
                ent_rcv[e]   <= '0;
                for (int i = 0; i < NUM_LANES; i++) ent_data[e][i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_tmask_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            out_idx     <= '0;
        end else begin
            ent_state <= nxt_state;
            ent_tag   <= nxt_tag;
            ent_exp   <= nxt_exp;
            ent_rcv   <= nxt_rcv;
            ent_data  <= nxt_data;
            if (out_load) begin
                rsp_valid_q <= 1'b1;
                out_idx     <= out_sel;
                rsp_tmask_q <= nxt_rcv[out_sel];
                rsp_data_q  <= out_data;
                rsp_tag_q   <= nxt_tag[out_sel];
            end else if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tmask = rsp_tmask_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;

`ifdef DMEM_RSP_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < NUM_ENTRIES; e++) ent_tmr[e] <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ent_tmr <= nxt_tmr;
            if (tmo_fire) timeout_err_q <= 1'b1;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_tmo;
    assign unused_tmo      = (TIMEOUT_CYCLES > 0);
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_vx_dmem_rsp_collector.sv
// Directed self-checking bench for vx_dmem_rsp_collector (4 lanes, 10-bit tags, 32-bit data).
module tb_vx_dmem_rsp_collector;
    logic clock;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    vx_dmem_rsp_collector_if #(.NUM_LANES(4), .TAG_WIDTH(10), .DATA_WIDTH(32)) bus ();

    vx_dmem_rsp_collector #(
        .NUM_LANES(4), .TAG_WIDTH(10), .DATA_WIDTH(32), .NUM_ENTRIES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_d();
        bus.mem_d_valid  = '0;
        bus.mem_d_opcode = {4{3'd1}};
        bus.mem_d_source = '0;
        bus.mem_d_data   = '0;
    endtask

    task automatic idle();
        bus.core_req_valid = '0;
        bus.core_req_rw    = '0;
        bus.core_req_tag   = '0;
        bus.mem_a_ready    = 4'hF;
        bus.rsp_ready      = 1'b1;
        idle_d();
    endtask

    task automatic d_beat(input int ln, input logic [9:0] src, input logic [31:0] dat, input logic [2:0] op);
        bus.mem_d_valid[ln]          = 1'b1;
        bus.mem_d_opcode[ln*3 +: 3]  = op;
        bus.mem_d_source[ln*10 +: 10] = src;
        bus.mem_d_data[ln*32 +: 32]  = dat;
    endtask

    initial begin
        logic [9:0] tg [4];
        logic       got;
        tg[0] = 10'h002; tg[1] = 10'h003; tg[2] = 10'h004; tg[3] = 10'h009;

        // Reset values
        idle();
        reset_n = 1'b0;
        #12;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_tmask", bus.rsp_tmask, 4'h0);
        chk("rst_rsp_data", bus.rsp_data, 128'h0);
        chk("rst_rsp_tag", bus.rsp_tag, 10'h0);
        chk("rst_timeout_err", bus.timeout_err, 1'b0);
        chk("rst_core_ready", bus.core_req_ready, 4'hF);
        reset_n = 1'b1;
        step();

        // Tag 0x05, staggered beats, one duplicate held off on lane0
        bus.core_req_valid = 4'hF; bus.core_req_tag = 10'h005;
        settle();
        chk("t1_req_ready", bus.core_req_ready, 4'hF);
        step(); idle();                                   // t1
        step(); d_beat(0, 10'h005, 32'hA0, 3'd1);         // t2
        settle();
        chk("t1_d_ready_first", bus.mem_d_ready, 4'hF);
        step(); idle_d();                                 // t3
        d_beat(3, 10'h005, 32'hA3, 3'd1);
        d_beat(0, 10'h005, 32'hEE, 3'd1);
        settle();
        chk("t1_dup_ready", bus.mem_d_ready, 4'b1110);
        chk("t1_no_rsp_t3", bus.rsp_valid, 1'b0);
        step(); idle_d();                                 // t4
        step();                                           // t5
        d_beat(1, 10'h005, 32'hA1, 3'd1);
        d_beat(2, 10'h005, 32'hA2, 3'd1);
        settle();
        chk("t1_no_rsp_t5", bus.rsp_valid, 1'b0);
        step(); idle_d();                                 // t6
        chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t1_rsp_tmask", bus.rsp_tmask, 4'hF);
        chk("t1_rsp_data", bus.rsp_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_rsp_tag", bus.rsp_tag, 10'h005);
        step();
        chk("t1_rsp_cleared", bus.rsp_valid, 1'b0);

        // Capacity: four tags outstanding, fifth stalls until first response fires
        for (int k = 1; k <= 4; k++) begin
            bus.core_req_valid = 4'h1; bus.core_req_tag = 10'(k);
            step();
        end
        bus.core_req_valid = 4'h1; bus.core_req_tag = 10'h009;
        settle();
        chk("t2_full_stall", bus.core_req_ready, 4'h0);
        d_beat(0, 10'h001, 32'h11, 3'd1);
        settle();
        chk("t2_stall_beat", bus.core_req_ready, 4'h0);
        step(); idle_d();
        chk("t2_rsp1_valid", bus.rsp_valid, 1'b1);
        chk("t2_rsp1_tag", bus.rsp_tag, 10'h001);
        chk("t2_stall_fire_cycle", bus.core_req_ready, 4'h0);
        step();
        chk("t2_fifth_ready", bus.core_req_ready, 4'hF);
        chk("t2_rsp_idle", bus.rsp_valid, 1'b0);
        step(); bus.core_req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            d_beat(0, tg[k], 32'h20 + 32'(k), 3'd1);
            step(); idle_d();
            chk("t2_drain_valid", bus.rsp_valid, 1'b1);
            chk("t2_drain_tag", bus.rsp_tag, tg[k]);
            chk("t2_drain_data", bus.rsp_data, {96'h0, 32'h20 + 32'(k)});
            chk("t2_drain_tmask", bus.rsp_tmask, 4'h1);
        end
        step();
        chk("t2_drained", bus.rsp_valid, 1'b0);

        // Stores: AccessAcks sunk, never a response
        bus.core_req_valid = 4'hF; bus.core_req_rw = 4'hF; bus.core_req_tag = 10'h002;
        settle();
        chk("t3_store_ready", bus.core_req_ready, 4'hF);
        step(); idle();
        for (int l = 0; l < 4; l++) d_beat(l, 10'h002, 32'h0, 3'd0);
        settle();
        chk("t3_ack_ready", bus.mem_d_ready, 4'hF);
        step(); idle_d();
        chk("t3_no_rsp_a", bus.rsp_valid, 1'b0);
        step();
        chk("t3_no_rsp_b", bus.rsp_valid, 1'b0);

        // Lane2 request fires three cycles after lanes 0,1
        bus.core_req_valid = 4'b0111; bus.core_req_tag = 10'h011; bus.mem_a_ready = 4'b1011;
        settle();
        chk("t4_ready_mask", bus.core_req_ready, 4'b1011);
        step();
        bus.core_req_valid = 4'b0100;
        d_beat(0, 10'h011, 32'hB0, 3'd1);
        d_beat(1, 10'h011, 32'hB1, 3'd1);
        step(); idle_d();
        chk("t4_wait_lane2_a", bus.rsp_valid, 1'b0);
        step();
        chk("t4_wait_lane2_b", bus.rsp_valid, 1'b0);
        bus.mem_a_ready = 4'hF;
        settle();
        chk("t4_lane2_ready", bus.core_req_ready, 4'hF);
        step(); bus.core_req_valid = '0;
        d_beat(2, 10'h011, 32'hB2, 3'd1);
        settle();
        chk("t4_wait_lane2_c", bus.rsp_valid, 1'b0);
        step(); idle_d();
        chk("t4_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t4_rsp_tmask", bus.rsp_tmask, 4'h7);
        chk("t4_rsp_data", bus.rsp_data, 128'h00000000_000000B2_000000B1_000000B0);
        chk("t4_rsp_tag", bus.rsp_tag, 10'h011);
        step();
        chk("t4_rsp_cleared", bus.rsp_valid, 1'b0);

        // Backpressure with two DONE entries
        bus.rsp_ready = 1'b0;
        bus.core_req_valid = 4'h1; bus.core_req_tag = 10'h021;
        step();
        bus.core_req_valid = 4'h2; bus.core_req_tag = 10'h022;
        step(); bus.core_req_valid = '0;
        d_beat(0, 10'h021, 32'hC0, 3'd1);
        d_beat(1, 10'h022, 32'hC1, 3'd1);
        step(); idle_d();
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", bus.rsp_valid, 1'b1);
            chk("t5_hold_tag", bus.rsp_tag, 10'h021);
            chk("t5_hold_data", bus.rsp_data, 128'h000000C0);
            step();
        end
        bus.rsp_ready = 1'b1;
        chk("t5_fire_tag", bus.rsp_tag, 10'h021);
        chk("t5_fire_tmask", bus.rsp_tmask, 4'h1);
        step();
        chk("t5_second_valid", bus.rsp_valid, 1'b1);
        chk("t5_second_tag", bus.rsp_tag, 10'h022);
        chk("t5_second_tmask", bus.rsp_tmask, 4'h2);
        chk("t5_second_data", bus.rsp_data, 128'h000000C1_00000000);
        step();
        chk("t5_rsp_cleared", bus.rsp_valid, 1'b0);

        // Lane3 never answers
        bus.core_req_valid = 4'hF; bus.core_req_tag = 10'h033;
        step(); bus.core_req_valid = '0;
        d_beat(0, 10'h033, 32'hD0, 3'd1);
        d_beat(1, 10'h033, 32'hD1, 3'd1);
        d_beat(2, 10'h033, 32'hD2, 3'd1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step(); idle_d();
            if (bus.rsp_valid) got = 1'b1;
        end
`ifdef DMEM_RSP_TIMEOUT_EN
        chk("t6_tmo_rsp", got, 1'b1);
        chk("t6_tmo_tmask", bus.rsp_tmask, 4'h7);
        chk("t6_tmo_data", bus.rsp_data, 128'h00000000_000000D2_000000D1_000000D0);
        chk("t6_tmo_err", bus.timeout_err, 1'b1);
`else
        chk("t6_partial_no_rsp", got, 1'b0);
        chk("t6_no_tmo_err", bus.timeout_err, 1'b0);
`endif

        // Reset mid-operation clears everything
        bus.core_req_valid = 4'h1; bus.core_req_tag = 10'h044;
        step(); bus.core_req_valid = '0;
        reset_n = 1'b0;
        settle();
        chk("t7_rst_valid", bus.rsp_valid, 1'b0);
        chk("t7_rst_err", bus.timeout_err, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        bus.core_req_valid = 4'hF; bus.core_req_tag = 10'h033;
        step(); bus.core_req_valid = '0;
        for (int l = 0; l < 4; l++) d_beat(l, 10'h033, 32'hE0 + 32'(l), 3'd1);
        settle();
        chk("t7_fresh_d_ready", bus.mem_d_ready, 4'hF);
        step(); idle_d();
        chk("t7_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t7_rsp_tmask", bus.rsp_tmask, 4'hF);
        chk("t7_rsp_data", bus.rsp_data, 128'h000000E3_000000E2_000000E1_000000E0);
        step();
        chk("t7_rsp_cleared", bus.rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
